aes_ecb_sched: RTL and testbench
================================

Name: aes_ecb_sched

Overview: Controller that sequences the AES-ECB core and shares it between two block requesters. It is typically fed by the AXI4-Lite register front-end and a streaming DMA port. It owns the key register and drives key expansion, round-robin arbitration, core start/complete handshaking, result return and a per-block watchdog. It sits between the S00_AXI register file / stream adapter and the AES core inside the AES_ECB IP.

Parameters:
TIMEOUT_CYC, 64, max cycles in WAIT before a block is aborted; counter width is clog2(TIMEOUT_CYC)+1.
RR_EN, 1, 1 = round-robin between requesters; 0 = fixed priority, req0 wins.

Ports:
ACLK  in  1  clock, rising edge.
ARESETN  in  1  reset, asynchronous assert, active-low.
key_wr  in  1  one-cycle strobe; latch key_in.
key_in  in  128  AES-128 key.
req0_valid / req1_valid  in  1  block request valid.
req0_ready / req1_ready  out  1  request accepted when valid and ready are both 1.
req0_data / req1_data  in  128  input block.
req0_dec / req1_dec  in  1  1 = decrypt, 0 = encrypt.
core_key_load  out  1  one-cycle pulse; start key expansion.
core_key  out  128  current key register.
core_key_ready  in  1  level; expanded key available.
core_start  out  1  one-cycle pulse; start a block.
core_din  out  128  block to core; held from ISSUE until done or timeout.
core_dec  out  1  direction to core; held with core_din.
core_done  in  1  one-cycle pulse; core_dout valid.
core_dout  in  128  core result.
res_valid  out  1  result valid.
res_ready  in  1  result consumer ready.
res_data  out  128  result block.
res_src  out  1  requester index of the result.
res_err  out  1  1 = timeout abort.
busy  out  1  state != IDLE or key_pending.
err_sticky  out  1  set on any timeout.
err_clr  in  1  clears err_sticky; set wins over clear in the same cycle.

Behaviour:
- Reset (ARESETN=0, async):
  - State = IDLE; key reg = 0; key_valid = 0; key_pending = 0; rr pointer = 0.
  - All outputs 0. Any in-flight block is discarded.
- key_wr in any state: key reg <= key_in; key_pending <= 1. The core is not touched until IDLE.
- States: IDLE, KEYEXP, ISSUE, WAIT, RESP.
- IDLE with key_pending=1 (priority over requests):
  - Go to KEYEXP and clear key_pending.
  - core_key_load=1 during the first KEYEXP cycle only.
- KEYEXP:
  - core_key_ready is ignored in the first cycle.
  - From the second cycle on, core_key_ready=1 → key_valid=1, go to IDLE.
  - key_wr while in KEYEXP sets key_pending again, so expansion reruns after return to IDLE.
- IDLE request grant:
  - reqN_ready is combinational: 1 iff state=IDLE, key_valid=1, key_pending=0 and N is granted.
  - Grant is to the single valid requester; if both are valid, grant goes to the rr pointer (RR_EN=1) or to 0 (RR_EN=0).
  - On handshake: latch data, dec and src; rr pointer <= ~src; go to ISSUE.
  - Requests without key_valid stall with ready=0.
- ISSUE (1 cycle): core_start=1; watchdog counter <= 0; go to WAIT.
- WAIT: counter increments each cycle.
  - core_done=1 → res_data <= core_dout, res_err <= 0, go to RESP.
  - Counter = TIMEOUT_CYC-1 without done → res_data <= 0, res_err <= 1, err_sticky <= 1, go to RESP.
  - done and timeout in the same cycle: done wins.
  - core_done outside WAIT is ignored.
- RESP:
  - res_valid=1; res_data, res_src and res_err held stable until res_ready.
  - On handshake, res_valid drops the next cycle and state returns to IDLE.
  - Minimum request-to-res_valid latency = 3 cycles plus core latency.
- key_wr during ISSUE/WAIT/RESP never affects the in-flight block. The new key is expanded before the next grant.

Test Plan:
- Basic encrypt:
  - Reset, then key_wr with 000102030405060708090a0b0c0d0e0f; core model raises ready 10 cycles after load.
  - req0 enc 00112233445566778899aabbccddeeff.
  - → exactly one core_key_load and one core_start; core_din matches the request.
  - → res_data=69c4e0d86a7b0430d8cdb78070b4c55a, res_src=0, res_err=0.
- No key: req0_valid asserted before any key_wr → req0_ready stays 0 and no core_start; after key expansion completes the request is accepted.
- Arbitration:
  - Both requesters hold valid for 4 blocks with RR_EN=1 → grants 0,1,0,1.
  - Same stimulus with RR_EN=0 → grants 0,0,0,0 while req0 stays valid.
- Timeout:
  - Core never pulses done → res_valid exactly TIMEOUT_CYC=64 cycles after entering WAIT, with res_err=1 and res_data=0.
  - err_sticky=1 until err_clr; a core_done arriving after the abort is ignored.
- Key change mid-block:
  - key_wr during WAIT → in-flight result returned unchanged.
  - Then core_key_load pulses before the next reqN_ready.
- Backpressure and reset:
  - res_ready held low 20 cycles → res_valid/res_data/res_src stable and both req readies 0.
  - ARESETN low mid-WAIT → all outputs 0 immediately and key_valid=0 after release.

Source files
------------

// File: rtl/aes_ecb_sched.sv
// Sequencer that shares one AES-ECB core between two block requesters. It owns the key
// register, triggers key expansion, arbitrates requests, runs the core handshake, bounds
// each block with a watchdog and returns results to a single consumer.
module aes_ecb_sched #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter bit          RR_EN       = 1'b1
) (
  input  logic         ACLK,
  input  logic         ARESETN,
  // Key programming
  input  logic         key_wr,
  input  logic [127:0] key_in,
  // Requester 0
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_data,
  input  logic         req0_dec,
  // Requester 1
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_data,
  input  logic         req1_dec,
  // AES core
  output logic         core_key_load,
  output logic [127:0] core_key,
  input  logic         core_key_ready,
  output logic         core_start,
  output logic [127:0] core_din,
  output logic         core_dec,
  input  logic         core_done,
  input  logic [127:0] core_dout,
  // Result
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_data,
  output logic         res_src,
  output logic         res_err,
  // Status
  output logic         busy,
  output logic         err_sticky,
  input  logic         err_clr
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StKeyExp,
    StIssue,
    StWait,
    StResp
  } state_e;

  state_e          state_q, state_d;
  logic [127:0]    key_q, key_d;
  logic            key_valid_q, key_valid_d;
  logic            key_pending_q, key_pending_d;
  logic            kexp_first_q, kexp_first_d;
  logic            rr_q, rr_d;
  logic [127:0]    din_q, din_d;
  logic            dec_q, dec_d;
  logic            src_q, src_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [127:0]    res_data_q, res_data_d;
  logic            res_err_q, res_err_d;
  logic            err_sticky_q, err_sticky_d;

  logic can_grant;
  logic gnt_src;
  logic gnt_any;
  logic err_set;

  // Arbitration: a lone valid requester wins; a tie goes to the rr pointer or to requester 0.
  always_comb begin
    can_grant = (state_q == StIdle) && key_valid_q && !key_pending_q;
    if (req0_valid && req1_valid) begin
      gnt_src = RR_EN ? rr_q : 1'b0;
    end else begin
      gnt_src = req1_valid;
    end
    gnt_any    = can_grant && (req0_valid || req1_valid);
    req0_ready = can_grant && req0_valid && !gnt_src;
    req1_ready = can_grant && req1_valid && gnt_src;
  end

  // Next-state logic for the sequencer and all holding registers.
  always_comb begin
    state_d       = state_q;
    key_d         = key_q;
    key_valid_d   = key_valid_q;
    key_pending_d = key_pending_q;
    kexp_first_d  = 1'b0;
    rr_d          = rr_q;
    din_d         = din_q;
    dec_d         = dec_q;
    src_d         = src_q;
    cnt_d         = cnt_q;
    res_data_d    = res_data_q;
    res_err_d     = res_err_q;
    err_set       = 1'b0;

    // A key write is only recorded here; the core sees it once the sequencer is idle.
    if (key_wr) begin
      key_d         = key_in;
      key_pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (key_pending_q) begin
          // The load pulse comes a cycle later and uses key_q, so a same-cycle key_wr is
          // already covered by this expansion.
          state_d       = StKeyExp;
          key_pending_d = 1'b0;
          kexp_first_d  = 1'b1;
        end else if (gnt_any) begin
          din_d   = gnt_src ? req1_data : req0_data;
          dec_d   = gnt_src ? req1_dec : req0_dec;
          src_d   = gnt_src;
          rr_d    = ~gnt_src;
          state_d = StIssue;
        end
      end
      StKeyExp: begin
        // core_key_ready may still be high from the previous key during the first cycle.
        if (!kexp_first_q && core_key_ready) begin
          key_valid_d = 1'b1;
          state_d     = StIdle;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (core_done) begin
          res_data_d = core_dout;
          res_err_d  = 1'b0;
          state_d    = StResp;
        end else if (cnt_q == CntLast) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
          err_set    = 1'b1;
          state_d    = StResp;
        end
      end
      StResp: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (err_set) begin
      err_sticky_d = 1'b1;
    end else if (err_clr) begin
      err_sticky_d = 1'b0;
    end else begin
      err_sticky_d = err_sticky_q;
    end
  end

  // State and datapath registers; reset discards any in-flight block.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q       <= StIdle;
      key_q         <= '0;
      key_valid_q   <= 1'b0;
      key_pending_q <= 1'b0;
      kexp_first_q  <= 1'b0;
      rr_q          <= 1'b0;
      din_q         <= '0;
      dec_q         <= 1'b0;
      src_q         <= 1'b0;
      cnt_q         <= '0;
      res_data_q    <= '0;
      res_err_q     <= 1'b0;
      err_sticky_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      key_q         <= key_d;
      key_valid_q   <= key_valid_d;
      key_pending_q <= key_pending_d;
      kexp_first_q  <= kexp_first_d;
      rr_q          <= rr_d;
      din_q         <= din_d;
      dec_q         <= dec_d;
      src_q         <= src_d;
      cnt_q         <= cnt_d;
      res_data_q    <= res_data_d;
      res_err_q     <= res_err_d;
      err_sticky_q  <= err_sticky_d;
    end
  end

  // Outputs decoded from state and held registers.
  always_comb begin
    core_key_load = (state_q == StKeyExp) && kexp_first_q;
    core_key      = key_q;
    core_start    = (state_q == StIssue);
    core_din      = din_q;
    core_dec      = dec_q;
    res_valid     = (state_q == StResp);
    res_data      = res_data_q;
    res_src       = src_q;
    res_err       = res_err_q;
    busy          = (state_q != StIdle) || key_pending_q;
    err_sticky    = err_sticky_q;
  end

endmodule

// File: tb/tb_aes_ecb_sched.sv
// Bench for aes_ecb_sched: a round-robin and a fixed-priority instance share stimulus, each
// with its own behavioural AES core; results are checked against a scoreboard queue.
module tb_aes_ecb_sched;

  localparam int unsigned TO = 64;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PA = 128'hdeadbeef_00000001_cafef00d_12345678;
  localparam logic [127:0] PB = 128'h0badc0de_11111111_22222222_33333333;
  localparam logic [127:0] INJ_DOUT = 128'hfeedfacefeedfacefeedfacefeedface;

  typedef struct packed {
    logic [127:0] data;
    logic         src;
    logic         err;
  } exp_t;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  logic         key_wr = 1'b0;
  logic [127:0] key_in = '0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [127:0] req0_data = '0, req1_data = '0;
  logic         req0_dec = 1'b0, req1_dec = 1'b0;
  logic         res_ready = 1'b0;
  logic         err_clr = 1'b0;
  logic         inj_done = 1'b0;
  logic         core_hang = 1'b0;
  int           core_lat = 4;
  logic [127:0] active_key = '0;

  logic [1:0]   req0_ready, req1_ready, core_key_load, core_start, core_dec;
  logic [1:0]   res_valid, res_src, res_err, busy, err_sticky;
  logic [127:0] core_key [2];
  logic [127:0] core_din [2];
  logic [127:0] res_data [2];

  exp_t exp_q[$];
  int   n_load = 0;
  int   n_start = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic logic [127:0] model(input logic [127:0] d, input logic dec,
                                         input logic [127:0] k);
    if (!dec && k == K1 && d == P1) return C1;
    return {d[63:0], d[127:64]} ^ k ^ {128{dec}};
  endfunction

  // Instance 0 round-robin, instance 1 fixed priority, each with a behavioural core.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    int           kcnt, bcnt;
    logic         kready, done_q, bdec;
    logic [127:0] kkey, bdin, dout_q;

    aes_ecb_sched #(.TIMEOUT_CYC(TO), .RR_EN(g == 0)) u_dut (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .key_wr        (key_wr),
      .key_in        (key_in),
      .req0_valid    (req0_valid),
      .req0_ready    (req0_ready[g]),
      .req0_data     (req0_data),
      .req0_dec      (req0_dec),
      .req1_valid    (req1_valid),
      .req1_ready    (req1_ready[g]),
      .req1_data     (req1_data),
      .req1_dec      (req1_dec),
      .core_key_load (core_key_load[g]),
      .core_key      (core_key[g]),
      .core_key_ready(kready),
      .core_start    (core_start[g]),
      .core_din      (core_din[g]),
      .core_dec      (core_dec[g]),
      .core_done     (done_q | inj_done),
      .core_dout     (inj_done ? INJ_DOUT : dout_q),
      .res_valid     (res_valid[g]),
      .res_ready     (res_ready),
      .res_data      (res_data[g]),
      .res_src       (res_src[g]),
      .res_err       (res_err[g]),
      .busy          (busy[g]),
      .err_sticky    (err_sticky[g]),
      .err_clr       (err_clr)
    );

    always @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
        kcnt <= 0; bcnt <= 0; kready <= 1'b0; done_q <= 1'b0;
        dout_q <= '0; kkey <= '0; bdin <= '0; bdec <= 1'b0;
      end else begin
        done_q <= 1'b0;
        if (core_key_load[g]) begin
          kcnt <= 10; kready <= 1'b0; kkey <= core_key[g];
        end else if (kcnt != 0) begin
          kcnt <= kcnt - 1;
          if (kcnt == 1) kready <= 1'b1;
        end
        if (core_start[g] && !core_hang) begin
          bcnt <= core_lat; bdin <= core_din[g]; bdec <= core_dec[g];
        end else if (bcnt != 0) begin
          bcnt <= bcnt - 1;
          if (bcnt == 1) begin
            done_q <= 1'b1;
            dout_q <= model(bdin, bdec, kkey);
          end
        end
      end
    end
  end

  // Scoreboard push on every accepted request of the round-robin instance.
  always @(posedge ACLK) begin
    if (!ARESETN) begin
      exp_q.delete();
    end else if (req0_valid && req0_ready[0]) begin
      exp_q.push_back('{core_hang ? '0 : model(req0_data, req0_dec, active_key), 1'b0, core_hang});
    end else if (req1_valid && req1_ready[0]) begin
      exp_q.push_back('{core_hang ? '0 : model(req1_data, req1_dec, active_key), 1'b1, core_hang});
    end
    if (ARESETN && core_key_load[0]) n_load <= n_load + 1;
    if (ARESETN && core_start[0]) n_start <= n_start + 1;
  end

  task automatic do_reset();
    @(negedge ACLK);
    ARESETN = 1'b0;
    key_wr = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    err_clr = 1'b0; inj_done = 1'b0; core_hang = 1'b0; core_lat = 4;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  task automatic write_key(input logic [127:0] k);
    @(negedge ACLK);
    key_wr = 1'b1; key_in = k; active_key = k;
    @(negedge ACLK);
    key_wr = 1'b0;
  endtask

  task automatic test_reset();
    logic [393:0] obs;
    @(negedge ACLK);
    ARESETN = 1'b0;
    #1;
    obs = {req0_ready[0], req1_ready[0], core_key_load[0], core_start[0], core_dec[0],
           res_valid[0], res_src[0], res_err[0], busy[0], err_sticky[0],
           core_key[0], core_din[0], res_data[0]};
    n_chk++;
    if (obs !== '0) $display("FAIL reset_outputs: got %h want 0", obs);
    else n_pass++;
    do_reset();
    @(negedge ACLK);
    n_chk++;
    if (busy[0] !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy[0]);
    else n_pass++;
  endtask

  task automatic test_basic_encrypt();
    int b_l, b_s;
    bit got;
    exp_t e;
    do_reset();
    b_l = n_load; b_s = n_start;
    res_ready = 1'b1;
    write_key(K1);
    req0_valid = 1'b1; req0_data = P1; req0_dec = 1'b0;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge ACLK);
      if (req0_ready[0]) begin got = 1; break; end
    end
    n_chk++;
    if (!got) $display("FAIL basic_grant: req0_ready got 0 want 1");
    else n_pass++;
    @(negedge ACLK);
    n_chk++;
    if ({core_start[0], core_dec[0], core_din[0]} !== {1'b1, 1'b0, P1})
      $display("FAIL basic_issue: got start=%b dec=%b din=%h want 1 0 %h",
               core_start[0], core_dec[0], core_din[0], P1);
    else n_pass++;
    req0_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge ACLK);
      if (res_valid[0]) begin got = 1; break; end
    end
    n_chk++;
    if (!got || exp_q.size() == 0) begin
      $display("FAIL basic_result: res_valid=%b queued=%0d want result", got, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if ({res_data[0], res_src[0], res_err[0]} !== {e.data, e.src, e.err})
        $display("FAIL basic_result: got %h src=%b err=%b want %h src=%b err=%b",
                 res_data[0], res_src[0], res_err[0], e.data, e.src, e.err);
      else n_pass++;
    end
    n_chk++;
    if (res_data[0] !== C1) $display("FAIL basic_vector: got %h want %h", res_data[0], C1);
    else n_pass++;
    @(negedge ACLK);
    n_chk++;
    if ({res_valid[0], n_load - b_l, n_start - b_s} !== {1'b0, 32'd1, 32'd1})
      $display("FAIL basic_counts: got res_valid=%b loads=%0d starts=%0d want 0 1 1",
               res_valid[0], n_load - b_l, n_start - b_s);
    else n_pass++;
  endtask

  task automatic test_no_key();
    int viol;
    bit got;
    exp_t e;
    do_reset();
    res_ready = 1'b1;
    req0_valid = 1'b1; req0_data = PA; req0_dec = 1'b1;
    viol = 0;
    repeat (20) begin
      @(negedge ACLK);
      if (req0_ready[0] || core_start[0]) viol++;
    end
    n_chk++;
    if (viol != 0) $display("FAIL nokey_stall: got %0d ready/start cycles want 0", viol);
    else n_pass++;
    write_key(K2);
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge ACLK);
      if (req0_ready[0]) begin got = 1; break; end
    end
    n_chk++;
    if (!got) $display("FAIL nokey_accept: req0_ready got 0 want 1");
    else n_pass++;
    @(negedge ACLK);
    req0_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge ACLK);
      if (res_valid[0]) begin got = 1; break; end
    end
    n_chk++;
    if (!got || exp_q.size() == 0) begin
      $display("FAIL nokey_result: res_valid=%b queued=%0d want result", got, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if ({res_data[0], res_src[0], res_err[0]} !== {e.data, e.src, e.err})
        $display("FAIL nokey_result: got %h src=%b err=%b want %h src=%b err=%b",
                 res_data[0], res_src[0], res_err[0], e.data, e.src, e.err);
      else n_pass++;
    end
  endtask

  task automatic test_arbitration();
    logic [3:0] exp_rr;
    logic [3:0] src0, src1;
    int n0, n1;
    exp_t e;
    exp_rr = 4'b1010;
    src0 = '0; src1 = '1;
    n0 = 0; n1 = 0;
    do_reset();
    res_ready = 1'b1;
    write_key(K1);
    req0_valid = 1'b1; req0_data = PA; req0_dec = 1'b0;
    req1_valid = 1'b1; req1_data = PB; req1_dec = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge ACLK);
      if (res_valid[0] && n0 < 4) begin
        src0[n0] = res_src[0];
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL arb_result%0d: queue empty want entry", n0);
        end else begin
          e = exp_q.pop_front();
          if ({res_data[0], res_src[0], res_err[0]} !== {e.data, e.src, e.err})
            $display("FAIL arb_result%0d: got %h src=%b want %h src=%b",
                     n0, res_data[0], res_src[0], e.data, e.src);
          else n_pass++;
        end
        n0++;
      end
      if (res_valid[1] && n1 < 4) begin
        src1[n1] = res_src[1];
        n1++;
      end
      if (n0 >= 4 && n1 >= 4) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        break;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_chk++;
    if (n0 != 4 || n1 != 4) $display("FAIL arb_count: got %0d/%0d results want 4/4", n0, n1);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (src0[k] !== exp_rr[k] || src1[k] !== 1'b0)
        $display("FAIL arb_grant%0d: got rr=%b fixed=%b want rr=%b fixed=0",
                 k, src0[k], src1[k], exp_rr[k]);
      else n_pass++;
    end
    @(negedge ACLK);
    @(negedge ACLK);
    n_chk++;
    if (exp_q.size() != 0) $display("FAIL arb_extra: got %0d extra grants want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_timeout();
    int cyc;
    bit got;
    exp_t e;
    do_reset();
    write_key(K1);
    core_hang = 1'b1;
    res_ready = 1'b0;
    req1_valid = 1'b1; req1_data = PB; req1_dec = 1'b0;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge ACLK);
      if (req1_ready[0]) begin got = 1; break; end
    end
    n_chk++;
    if (!got) $display("FAIL to_grant: req1_ready got 0 want 1");
    else n_pass++;
    @(negedge ACLK);
    req1_valid = 1'b0;
    cyc = 0; got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge ACLK);
      cyc++;
      if (res_valid[0]) begin got = 1; break; end
    end
    // The first negedge counted follows the edge entering WAIT.
    n_chk++;
    if (!got || cyc - 1 != TO)
      $display("FAIL to_latency: got %0d cycles (valid=%b) want %0d", cyc - 1, got, TO);
    else n_pass++;
    n_chk++;
    if (exp_q.size() == 0) begin
      $display("FAIL to_result: queue empty want entry");
    end else begin
      e = exp_q.pop_front();
      if ({res_data[0], res_src[0], res_err[0], err_sticky[0]} !== {e.data, e.src, e.err, 1'b1})
        $display("FAIL to_result: got %h src=%b err=%b sticky=%b want %h src=%b err=%b sticky=1",
                 res_data[0], res_src[0], res_err[0], err_sticky[0], e.data, e.src, e.err);
      else n_pass++;
    end
    inj_done = 1'b1;
    @(negedge ACLK);
    inj_done = 1'b0;
    n_chk++;
    if ({res_valid[0], res_err[0], res_data[0]} !== {1'b1, 1'b1, 128'h0})
      $display("FAIL to_late_done: got valid=%b err=%b data=%h want 1 1 0",
               res_valid[0], res_err[0], res_data[0]);
    else n_pass++;
    res_ready = 1'b1;
    @(negedge ACLK);
    n_chk++;
    if ({res_valid[0], err_sticky[0]} !== 2'b01)
      $display("FAIL to_release: got valid=%b sticky=%b want 0 1", res_valid[0], err_sticky[0]);
    else n_pass++;
    err_clr = 1'b1;
    @(negedge ACLK);
    err_clr = 1'b0;
    n_chk++;
    if (err_sticky[0] !== 1'b0) $display("FAIL to_clear: got sticky=%b want 0", err_sticky[0]);
    else n_pass++;
    core_hang = 1'b0;
  endtask

  task automatic test_key_change();
    int b_l;
    bit got;
    exp_t e;
    do_reset();
    write_key(K1);
    core_lat = 6;
    res_ready = 1'b1;
    req0_valid = 1'b1; req0_data = P1; req0_dec = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge ACLK);
      if (req0_ready[0]) break;
    end
    @(negedge ACLK);
    req0_valid = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    b_l = n_load;
    write_key(K2);
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge ACLK);
      if (res_valid[0]) begin got = 1; break; end
    end
    n_chk++;
    if (!got || exp_q.size() == 0) begin
      $display("FAIL kc_inflight: res_valid=%b queued=%0d want result", got, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if ({res_data[0], res_err[0], n_load - b_l} !== {e.data, e.err, 32'd0})
        $display("FAIL kc_inflight: got %h err=%b loads=%0d want %h err=%b loads=0",
                 res_data[0], res_err[0], n_load - b_l, e.data, e.err);
      else n_pass++;
    end
    req1_valid = 1'b1; req1_data = PB; req1_dec = 1'b0;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge ACLK);
      if (req1_ready[0]) begin got = 1; break; end
    end
    n_chk++;
    if (!got || n_load - b_l != 1)
      $display("FAIL kc_reload: got ready=%b loads=%0d want 1 1", got, n_load - b_l);
    else n_pass++;
    @(negedge ACLK);
    req1_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge ACLK);
      if (res_valid[0]) begin got = 1; break; end
    end
    n_chk++;
    if (!got || exp_q.size() == 0) begin
      $display("FAIL kc_newkey: res_valid=%b queued=%0d want result", got, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if ({res_data[0], res_src[0]} !== {e.data, e.src})
        $display("FAIL kc_newkey: got %h src=%b want %h src=%b",
                 res_data[0], res_src[0], e.data, e.src);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [129:0] snap;
    int viol;
    bit got;
    exp_t e;
    do_reset();
    write_key(K1);
    res_ready = 1'b0;
    req1_valid = 1'b1; req1_data = PA; req1_dec = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge ACLK);
      if (req1_ready[0]) break;
    end
    @(negedge ACLK);
    req0_valid = 1'b1; req0_data = PB; req0_dec = 1'b0;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge ACLK);
      if (res_valid[0]) begin got = 1; break; end
    end
    snap = {res_data[0], res_src[0], res_err[0]};
    viol = 0;
    repeat (20) begin
      @(negedge ACLK);
      if (!res_valid[0] || {res_data[0], res_src[0], res_err[0]} !== snap ||
          req0_ready[0] || req1_ready[0]) viol++;
    end
    n_chk++;
    if (!got || viol != 0)
      $display("FAIL bp_stable: got valid=%b unstable=%0d want 1 0", got, viol);
    else n_pass++;
    n_chk++;
    if (exp_q.size() == 0) begin
      $display("FAIL bp_result: queue empty want entry");
    end else begin
      e = exp_q.pop_front();
      if ({res_data[0], res_src[0], res_err[0]} !== {e.data, e.src, e.err})
        $display("FAIL bp_result: got %h src=%b err=%b want %h src=%b err=%b",
                 res_data[0], res_src[0], res_err[0], e.data, e.src, e.err);
      else n_pass++;
    end
    res_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge ACLK);
    n_chk++;
    if (res_valid[0] !== 1'b0) $display("FAIL bp_release: got valid=%b want 0", res_valid[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [393:0] obs;
    int viol;
    do_reset();
    write_key(K1);
    core_hang = 1'b1;
    req0_valid = 1'b1; req0_data = PA; req0_dec = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge ACLK);
      if (req0_ready[0]) break;
    end
    @(negedge ACLK);
    req0_valid = 1'b0;
    repeat (5) @(negedge ACLK);
    #2;
    ARESETN = 1'b0;
    #1;
    obs = {req0_ready[0], req1_ready[0], core_key_load[0], core_start[0], core_dec[0],
           res_valid[0], res_src[0], res_err[0], busy[0], err_sticky[0],
           core_key[0], core_din[0], res_data[0]};
    n_chk++;
    if (obs !== '0) $display("FAIL rstmid_outputs: got %h want 0", obs);
    else n_pass++;
    @(negedge ACLK);
    ARESETN = 1'b1;
    core_hang = 1'b0;
    req0_valid = 1'b1;
    viol = 0;
    repeat (15) begin
      @(negedge ACLK);
      if (req0_ready[0] || busy[0] || core_start[0]) viol++;
    end
    n_chk++;
    if (viol != 0) $display("FAIL rstmid_nokey: got %0d active cycles want 0", viol);
    else n_pass++;
    req0_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_encrypt();
    test_no_key();
    test_arbitration();
    test_timeout();
    test_key_change();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
